// File: rtl/traffic_light_monitor.sv
// Passive monitor for the intersection light buses: decodes and times phases, flags errors.
// Optional MONITOR_LOG_EN: simulation-only logging of phase entries and new errors.
module traffic_light_monitor #(
  parameter int unsigned MIN_YELLOW = 4,
  parameter int unsigned MAX_GREEN  = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       first_carsLights,
  input  logic [2:0]       second_carsLights,
  input  logic [1:0]       first_pedestrianLights,
  input  logic [1:0]       second_pedestrianLights,
  input  logic             clear_errors,
  output logic [2:0]       phase,
  output logic             phase_change,
  output logic [CNT_W-1:0] phase_cycles,
  output logic [15:0]      full_cycles,
  output logic             err_encoding,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_timing,
  output logic             err_any
);

  localparam int unsigned ERR_W   = 4;
  localparam int unsigned FULL_W  = 16;
  localparam int unsigned E_ENC   = 0;
  localparam int unsigned E_CONF  = 1;
  localparam int unsigned E_SEQ   = 2;
  localparam int unsigned E_TIM   = 3;

  localparam logic [2:0] CAR_G    = 3'b001;
  localparam logic [2:0] CAR_Y    = 3'b010;
  localparam logic [2:0] CAR_R    = 3'b100;
  localparam logic [1:0] PED_WALK = 2'b10;
  localparam logic [1:0] PED_DONT = 2'b01;

  typedef enum logic [2:0] {
    PH_SYNC = 3'd0,
    PH_G1   = 3'd1,
    PH_Y1   = 3'd2,
    PH_G2   = 3'd3,
    PH_Y2   = 3'd4
  } phase_e;

  logic [2:0]        car1_q, car2_q;
  logic [1:0]        ped1_q, ped2_q;
  logic              smp_vld_q;

  phase_e            phase_q, phase_d;
  logic              chg_q, chg_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [FULL_W-1:0] full_q, full_d;
  logic [ERR_W-1:0]  err_q, err_d, err_set;
  logic              any_q;

  phase_e            pat;
  logic              pat_vld;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_G1:   return PH_Y1;
      PH_Y1:   return PH_G2;
      PH_G2:   return PH_Y2;
      PH_Y2:   return PH_G1;
      default: return PH_SYNC;
    endcase
  endfunction

  function automatic logic car_ok(input logic [2:0] c);
    return (c == CAR_G) || (c == CAR_Y) || (c == CAR_R);
  endfunction

  function automatic logic ped_ok(input logic [1:0] p);
    return (p == PED_WALK) || (p == PED_DONT);
  endfunction

  // Pattern decode from the registered bus copy
  always_comb begin
    pat     = PH_SYNC;
    pat_vld = 1'b0;
    if (car2_q == CAR_R && car1_q == CAR_G) begin
      pat = PH_G1; pat_vld = 1'b1;
    end else if (car2_q == CAR_R && car1_q == CAR_Y) begin
      pat = PH_Y1; pat_vld = 1'b1;
    end else if (car1_q == CAR_R && car2_q == CAR_G) begin
      pat = PH_G2; pat_vld = 1'b1;
    end else if (car1_q == CAR_R && car2_q == CAR_Y) begin
      pat = PH_Y2; pat_vld = 1'b1;
    end
  end

  assign cyc_inc = (cyc_q == {CNT_W{1'b1}}) ? cyc_q : cyc_q + CNT_W'(1);

  // Phase tracking, timing and error evaluation
  always_comb begin
    phase_d = phase_q;
    chg_d   = 1'b0;
    cyc_d   = cyc_q;
    full_d  = full_q;
    err_set = '0;

    if (smp_vld_q) begin
      err_set[E_ENC]  = !car_ok(car1_q) || !car_ok(car2_q) ||
                        !ped_ok(ped1_q) || !ped_ok(ped2_q);
      // Each side's pedestrians cross the other side's car lanes
      err_set[E_CONF] = (car1_q != CAR_R && car2_q != CAR_R) ||
                        (ped1_q == PED_WALK && car2_q != CAR_R) ||
                        (ped2_q == PED_WALK && car1_q != CAR_R);

      if (phase_q == PH_SYNC) begin
        if (pat_vld) begin
          phase_d = pat;
          chg_d   = 1'b1;
          cyc_d   = CNT_W'(1);
        end
      end else if (!pat_vld || pat == phase_q) begin
        cyc_d = cyc_inc;
        if ((phase_q == PH_G1 || phase_q == PH_G2) && cyc_inc != cyc_q &&
            32'(cyc_inc) == MAX_GREEN + 1)
          err_set[E_TIM] = 1'b1;
      end else begin
        if ((phase_q == PH_Y1 || phase_q == PH_Y2) && 32'(cyc_q) < MIN_YELLOW)
          err_set[E_TIM] = 1'b1;
        if (pat == next_phase(phase_q)) begin
          chg_d = 1'b1;
          if (phase_q == PH_Y2)
            full_d = full_q + FULL_W'(1);
        end else begin
          err_set[E_SEQ] = 1'b1;
        end
        phase_d = pat;
        cyc_d   = CNT_W'(1);
      end
    end

    err_d = clear_errors ? '0 : (err_q | err_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car1_q    <= '0;
      car2_q    <= '0;
      ped1_q    <= '0;
      ped2_q    <= '0;
      smp_vld_q <= 1'b0;
      phase_q   <= PH_SYNC;
      chg_q     <= 1'b0;
      cyc_q     <= '0;
      full_q    <= '0;
      err_q     <= '0;
      any_q     <= 1'b0;
    end else begin
      car1_q    <= first_carsLights;
      car2_q    <= second_carsLights;
      ped1_q    <= first_pedestrianLights;
      ped2_q    <= second_pedestrianLights;
      smp_vld_q <= 1'b1;
      phase_q   <= phase_d;
      chg_q     <= chg_d;
      cyc_q     <= cyc_d;
      full_q    <= full_d;
      err_q     <= err_d;
      any_q     <= |err_d;
    end
  end

  assign phase        = phase_q;
  assign phase_change = chg_q;
  assign phase_cycles = cyc_q;
  assign full_cycles  = full_q;
  assign err_encoding = err_q[E_ENC];
  assign err_conflict = err_q[E_CONF];
  assign err_sequence = err_q[E_SEQ];
  assign err_timing   = err_q[E_TIM];
  assign err_any      = any_q;

`ifdef MONITOR_LOG_EN
  always @(posedge clk) begin
    if (rst_n && (chg_d || |(err_d & ~err_q)))
      $display("%0t phase=%0d cycles=%0d err=%b", $time, phase_d, cyc_d, err_d);
  end
`endif

endmodule
